// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared types and constants for the 7-segment scan controller.
//               scan_state_t  - slot phase (GAP = anodes off, DRIVE = digit on)
//               hex_digit_t   - one hex nibble
//               SEG_OFF       - active-low segment pattern with every segment dark
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef enum logic {
        GAP   = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    typedef logic [3:0] hex_digit_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decoder
// Description : Combinational hex-to-7-segment decoder, active-low outputs
//               ordered {g,f,e,d,c,b,a} (bit 0 = segment a).
// Ports       : i_hex  in  4  hex digit
//               o_seg  out 7  active-low segment pattern
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  hex_digit_t  i_hex,
    output logic [6:0]  o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_hex)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : seg7_slot_timer
// Description : Per-digit slot sequencer. Each slot is GUARD cycles of GAP
//               (all anodes off) followed by TICK_DIV-GUARD cycles of DRIVE.
//               The digit index advances at the end of every DRIVE phase and
//               wraps to 0 after the last digit; o_wrap flags that edge.
// Ports       : clk      in  1      system clock
//               rst      in  1      synchronous active-high reset
//               o_state  out 1      current slot phase
//               o_idx    out IDX_W  digit currently being scanned
//               o_wrap   out 1      high in the final DRIVE cycle of the last
//                                   digit (the next edge starts a new frame)
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000,
    parameter int GUARD      = 4,
    parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    output scan_state_t       o_state,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_wrap
);

    // The counter restarts on each phase change, so it never exceeds
    // max(GUARD, TICK_DIV-GUARD) - 1 < TICK_DIV.
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0] C_GAP_LAST   = CNT_W'(GUARD - 1);
    localparam logic [CNT_W-1:0] C_DRIVE_LAST = CNT_W'(TICK_DIV - GUARD - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t       r_state;
    scan_state_t       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= GAP;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_wrap      = 1'b0;
        case (r_state)
            GAP: begin
                if (r_cnt == C_GAP_LAST) begin
                    w_state_nxt = DRIVE;
                    w_cnt_nxt   = '0;
                end
            end
            DRIVE: begin
                if (r_cnt == C_DRIVE_LAST) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = '0;
                    if (r_idx == C_IDX_LAST) begin
                        w_idx_nxt = '0;
                        w_wrap    = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = GAP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_state = r_state;
    assign o_idx   = r_idx;
    assign o_wrap  = w_wrap;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_controller
// Description : Time-multiplexed hex display driver for NUM_DIGITS
//               common-anode digits. A loaded value waits in a shadow
//               register and is committed to the display register only at
//               the start of a frame, so a frame never mixes old and new
//               digits. One shared hex decoder feeds all digits.
// Ports       : clk          in  1             system clock
//               rst          in  1             synchronous active-high reset
//               load         in  1             capture value into shadow
//               value        in  4*NUM_DIGITS  nibble i -> digit i
//               blank        in  1             force display dark
//               anodes       out NUM_DIGITS    active-low digit enables
//               segments     out 7             active-low {g,f,e,d,c,b,a}
//               pending      out 1             shadow not yet committed
//               frame_start  out 1             pulse at each commit point
// Config      : LEADING_ZERO_BLANK_EN - when defined, digits above the most
//               significant non-zero nibble stay dark (digit 0 always shown).
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000,
    parameter int GUARD      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [4*NUM_DIGITS-1:0]  value,
    input  logic                     blank,
    output logic [NUM_DIGITS-1:0]    anodes,
    output logic [6:0]               segments,
    output logic                     pending,
    output logic                     frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    scan_state_t              w_state;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_wrap;

    logic [4*NUM_DIGITS-1:0]  r_shadow;
    logic [4*NUM_DIGITS-1:0]  r_display;
    logic                     r_pending;
    logic                     r_frame_start;
    logic [NUM_DIGITS-1:0]    r_anodes;
    logic [6:0]               r_segments;

    hex_digit_t               w_nibble;
    logic [6:0]               w_seg_dec;
    logic                     w_lz_dark;
    logic [NUM_DIGITS-1:0]    w_anodes_nxt;
    logic [6:0]               w_segments_nxt;

    seg7_slot_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .TICK_DIV   (TICK_DIV),
        .GUARD      (GUARD),
        .IDX_W      (IDX_W)
    ) u_slot_timer (
        .clk     (clk),
        .rst     (rst),
        .o_state (w_state),
        .o_idx   (w_idx),
        .o_wrap  (w_wrap)
    );

    assign w_nibble = hex_digit_t'(r_display >> {w_idx, 2'b00});

    seg7_hex_decoder u_hex_decoder (
        .i_hex (w_nibble),
        .o_seg (w_seg_dec)
    );

    always_comb begin
        w_anodes_nxt   = '1;
        w_segments_nxt = SEG_OFF;
        w_lz_dark      = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        // Shifting the current digit down to bit 0 leaves only the nibbles
        // at and above it; all-zero means this is a leading zero.
        w_lz_dark = (w_idx != '0) && ((r_display >> {w_idx, 2'b00}) == '0);
`endif
        if ((w_state == DRIVE) && !blank && !w_lz_dark) begin
            w_anodes_nxt   = ~(NUM_DIGITS'(1) << w_idx);
            w_segments_nxt = w_seg_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow      <= '0;
            r_display     <= '0;
            r_pending     <= 1'b0;
            r_frame_start <= 1'b0;
            r_anodes      <= '1;
            r_segments    <= SEG_OFF;
        end else begin
            r_frame_start <= w_wrap;
            r_anodes      <= w_anodes_nxt;
            r_segments    <= w_segments_nxt;
            // The commit reads the shadow before a same-cycle load replaces
            // it, so a coincident load waits for the next frame.
            if (w_wrap && r_pending) begin
                r_display <= r_shadow;
            end
            if (load) begin
                r_shadow  <= value;
                r_pending <= 1'b1;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign anodes      = r_anodes;
    assign segments    = r_segments;
    assign pending     = r_pending;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_controller
// Description : Self-checking bench for seg7_scan_controller with
//               NUM_DIGITS=4, TICK_DIV=8, GUARD=2. A timeline model derives
//               every expected output from the cycle count since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_controller;

    localparam int ND = 4;
    localparam int TD = 8;
    localparam int GD = 2;
    localparam int FR = ND * TD;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic          blank = 1'b0;
    logic [3:0]    anodes;
    logic [6:0]    segments;
    logic          pending;
    logic          frame_start;

    int checks = 0;
    int errors = 0;

    // Model state: t = cycles since reset release.
    int            t = 0;
    logic [15:0]   m_shadow = '0;
    logic [15:0]   m_display = '0;
    logic          m_pending = 1'b0;
    logic [3:0]    exp_anodes = '1;
    logic [6:0]    exp_segments = 7'h7F;
    logic          exp_pending = 1'b0;
    logic          exp_fs = 1'b0;

    // Lit segments of each hex glyph.
    string SEG_LIT [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                            "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                            "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    seg7_scan_controller #(
        .NUM_DIGITS (ND),
        .TICK_DIV   (TD),
        .GUARD      (GD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .value       (value),
        .blank       (blank),
        .anodes      (anodes),
        .segments    (segments),
        .pending     (pending),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int h);
        logic [6:0] s;
        string      lit;
        s   = 7'h7F;
        lit = SEG_LIT[h];
        for (int i = 0; i < lit.len(); i++) s[int'(lit[i]) - 97] = 1'b0;
        return s;
    endfunction

    // Drive one cycle of inputs, advance the clock and update the model.
    task automatic tick(input logic r, input logic ld, input logic [15:0] v, input logic bl);
        logic [15:0] disp_before;
        int p, d;
        rst = r; load = ld; value = v; blank = bl;
        disp_before = m_display;
        @(posedge clk);
        #1;
        if (r) begin
            t = 0; m_shadow = '0; m_display = '0; m_pending = 1'b0;
            exp_anodes = '1; exp_segments = 7'h7F; exp_pending = 1'b0; exp_fs = 1'b0;
        end else begin
            t++;
            exp_fs = (t % FR == 0);
            if (exp_fs && m_pending) begin
                m_display = m_shadow;
                m_pending = 1'b0;
            end
            if (ld) begin
                m_shadow  = v;
                m_pending = 1'b1;
            end
            exp_pending  = m_pending;
            exp_anodes   = '1;
            exp_segments = 7'h7F;
            // Outputs lag by one cycle: they show the slot position of t-1.
            p = t - 1;
            d = (p / TD) % ND;
            if ((p % TD) >= GD && !bl && !(LZB && d > 0 && (disp_before >> (4 * d)) == 16'h0)) begin
                exp_anodes   = ~(4'b0001 << d);
                exp_segments = seg_of(int'(disp_before[4 * d +: 4]));
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 16'hFFFF, 1'b0);
            checks++;
            if ({anodes, segments, pending, frame_start} !== {4'hF, 7'h7F, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset cyc=%0d got an=%b seg=%h pend=%b fs=%b want an=1111 seg=7f pend=0 fs=0",
                         i, anodes, segments, pending, frame_start);
            end
        end
    endtask

    task automatic test_scan_order();
        int fs_times[$];
        int d0_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b0);
            checks++;
            if ({anodes, segments, pending, frame_start} !== {exp_anodes, exp_segments, exp_pending, exp_fs}) begin
                errors++;
                $display("FAIL scan t=%0d got an=%b seg=%h pend=%b fs=%b want an=%b seg=%h pend=%b fs=%b",
                         t, anodes, segments, pending, frame_start, exp_anodes, exp_segments, exp_pending, exp_fs);
            end
            if (frame_start) fs_times.push_back(t);
            if (anodes == 4'b1110) d0_cnt++;
        end
        checks++;
        if (fs_times.size() != 2 || fs_times[1] - fs_times[0] != 32) begin
            errors++;
            $display("FAIL scan_fs_period got pulses=%0d want 2 pulses 32 apart", fs_times.size());
        end
        checks++;
        if (d0_cnt != 12) begin
            errors++;
            $display("FAIL scan_digit0_cycles got %0d want 12", d0_cnt);
        end
    endtask

    task automatic test_commit();
        bit seen_fs = 0, saw4 = 0, saw1 = 0;
        for (int i = 0; i < FR && (t % FR) != 10; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b0, 1'b1, 16'h1234, 1'b0);
        for (int i = 0; i < 2 * FR; i++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b0);
            checks++;
            if ({anodes, segments, pending, frame_start} !== {exp_anodes, exp_segments, exp_pending, exp_fs}) begin
                errors++;
                $display("FAIL commit t=%0d got an=%b seg=%h pend=%b fs=%b want an=%b seg=%h pend=%b fs=%b",
                         t, anodes, segments, pending, frame_start, exp_anodes, exp_segments, exp_pending, exp_fs);
            end
            if (frame_start) seen_fs = 1;
            if (seen_fs && anodes == 4'b1110 && segments == 7'h19) saw4 = 1;
            if (seen_fs && anodes == 4'b0111 && segments == 7'h79) saw1 = 1;
            checks++;
            if (pending !== !seen_fs) begin
                errors++;
                $display("FAIL commit_pending t=%0d got %b want %b", t, pending, !seen_fs);
            end
        end
        checks++;
        if (!(saw4 && saw1)) begin
            errors++;
            $display("FAIL commit_digits got saw4=%0d saw1=%0d want 1 1", saw4, saw1);
        end
    endtask

    task automatic test_overwrite();
        bit seen_fs = 0;
        int n = 0, upper_cnt = 0, d0_cnt = 0;
        for (int i = 0; i < FR && (t % FR) != 5; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b0, 1'b1, 16'hABCD, 1'b0);
        for (int i = 0; i < 9; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b0, 1'b1, 16'h0005, 1'b0);
        for (int i = 0; i < 2 * FR && n < FR; i++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b0);
            checks++;
            if ({anodes, segments, pending, frame_start} !== {exp_anodes, exp_segments, exp_pending, exp_fs}) begin
                errors++;
                $display("FAIL overwrite t=%0d got an=%b seg=%h pend=%b fs=%b want an=%b seg=%h pend=%b fs=%b",
                         t, anodes, segments, pending, frame_start, exp_anodes, exp_segments, exp_pending, exp_fs);
            end
            if (seen_fs) begin
                n++;
                if ((anodes == 4'b1101 || anodes == 4'b1011 || anodes == 4'b0111) && segments == 7'h40) upper_cnt++;
                if (anodes == 4'b1110 && segments == 7'h12) d0_cnt++;
            end
            if (frame_start) seen_fs = 1;
        end
        checks++;
        if (upper_cnt != (LZB ? 0 : 18)) begin
            errors++;
            $display("FAIL overwrite_upper got %0d want %0d", upper_cnt, LZB ? 0 : 18);
        end
        checks++;
        if (d0_cnt != 6) begin
            errors++;
            $display("FAIL overwrite_digit0 got %0d want 6", d0_cnt);
        end
    endtask

    task automatic test_coincident();
        int c_cnt = 0, s_cnt = 0;
        for (int i = 0; i < FR && (t % FR) != 12; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b0, 1'b1, 16'h0C00, 1'b0);
        for (int i = 0; i < FR && (t % FR) != FR - 1; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b0, 1'b1, 16'h0007, 1'b0);
        checks++;
        if ({pending, frame_start} !== 2'b11) begin
            errors++;
            $display("FAIL coincident_pend got pend=%b fs=%b want pend=1 fs=1", pending, frame_start);
        end
        for (int i = 0; i < 2 * FR; i++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b0);
            checks++;
            if ({anodes, segments, pending, frame_start} !== {exp_anodes, exp_segments, exp_pending, exp_fs}) begin
                errors++;
                $display("FAIL coincident t=%0d got an=%b seg=%h pend=%b fs=%b want an=%b seg=%h pend=%b fs=%b",
                         t, anodes, segments, pending, frame_start, exp_anodes, exp_segments, exp_pending, exp_fs);
            end
            if (i < FR && anodes == 4'b1011 && segments == 7'h46) c_cnt++;
            if (i >= FR && anodes == 4'b1110 && segments == 7'h78) s_cnt++;
        end
        checks++;
        if (c_cnt != 6 || s_cnt != 6) begin
            errors++;
            $display("FAIL coincident_frames got oldC=%0d new7=%0d want 6 6", c_cnt, s_cnt);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < FR && (t % FR) != 2 * TD + 4; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b0, 1'b1, 16'h9999, 1'b0);
        checks++;
        if (anodes !== 4'b1011) begin
            errors++;
            $display("FAIL reset_mid_pre got an=%b want 1011", anodes);
        end
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        checks++;
        if ({anodes, segments, pending, frame_start} !== {4'hF, 7'h7F, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got an=%b seg=%h pend=%b fs=%b want an=1111 seg=7f pend=0 fs=0",
                     anodes, segments, pending, frame_start);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
        checks++;
        if ({anodes, segments} !== {4'b1110, 7'h40}) begin
            errors++;
            $display("FAIL reset_mid_restart got an=%b seg=%h want an=1110 seg=40", anodes, segments);
        end
    endtask

    task automatic test_blank();
        int fs_times[$];
        int lit_cnt = 0;
        bit gap_ok = 1;
        for (int i = 0; i < 2 * FR + 8; i++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b1);
            checks++;
            if ({anodes, segments, pending, frame_start} !== {exp_anodes, exp_segments, exp_pending, exp_fs}) begin
                errors++;
                $display("FAIL blank t=%0d got an=%b seg=%h pend=%b fs=%b want an=%b seg=%h pend=%b fs=%b",
                         t, anodes, segments, pending, frame_start, exp_anodes, exp_segments, exp_pending, exp_fs);
            end
            if (anodes != 4'hF || segments != 7'h7F) lit_cnt++;
            if (frame_start) fs_times.push_back(t);
        end
        for (int i = 1; i < fs_times.size(); i++) if (fs_times[i] - fs_times[i - 1] != FR) gap_ok = 0;
        checks++;
        if (lit_cnt != 0 || fs_times.size() < 2 || !gap_ok) begin
            errors++;
            $display("FAIL blank_dark got lit=%0d pulses=%0d spacing_ok=%0d want 0 >=2 1",
                     lit_cnt, fs_times.size(), gap_ok);
        end
    endtask

    task automatic test_random();
        logic bl = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) bl = ~bl;
            tick(1'b0, ($urandom_range(7) == 0), 16'($urandom), bl);
            checks++;
            if ({anodes, segments, pending, frame_start} !== {exp_anodes, exp_segments, exp_pending, exp_fs}) begin
                errors++;
                $display("FAIL random t=%0d got an=%b seg=%h pend=%b fs=%b want an=%b seg=%h pend=%b fs=%b",
                         t, anodes, segments, pending, frame_start, exp_anodes, exp_segments, exp_pending, exp_fs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_commit();
        test_overwrite();
        test_coincident();
        test_reset_mid();
        test_blank();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
